// File: rtl/tower_placer_pkg.sv
// Shared types for the tower-placement control slice: FSM states, strobe bundle and grid constants.
package tower_placer_pkg;

  localparam int unsigned GRID_COLS = 8;
  localparam int unsigned GRID_ROWS = 6;
  localparam int unsigned CELL_PX   = 20;
  localparam int unsigned TIMEOUT_W = 11;

  typedef enum logic [3:0] {
    IDLE,
    TOP_LEFT,
    DRAW_SQUARE,
    WAIT_INPUT,
    ERASE_RIGHT,
    MOVE_RIGHT,
    RIGHT_WAIT,
    ERASE_DOWN,
    MOVE_DOWN,
    DOWN_WAIT,
    ERASE_TOWER,
    DRAW_TOWER,
    DONE
  } state_t;

  typedef struct packed {
    logic top_left;
    logic draw_square;
    logic move_right;
    logic move_down;
    logic move_right_wait;
    logic move_down_wait;
    logic erase_square_right;
    logic erase_square_down;
    logic erase_square_tower;
    logic draw_tower;
  } strobes_t;

  // One strobe per active state; IDLE, WAIT_INPUT and DONE drive none.
  function automatic strobes_t decode_strobes(input state_t s);
    strobes_t st;
    st = '0;
    case (s)
      TOP_LEFT:    st.top_left           = 1'b1;
      DRAW_SQUARE: st.draw_square        = 1'b1;
      ERASE_RIGHT: st.erase_square_right = 1'b1;
      MOVE_RIGHT:  st.move_right         = 1'b1;
      RIGHT_WAIT:  st.move_right_wait    = 1'b1;
      ERASE_DOWN:  st.erase_square_down  = 1'b1;
      MOVE_DOWN:   st.move_down          = 1'b1;
      DOWN_WAIT:   st.move_down_wait     = 1'b1;
      ERASE_TOWER: st.erase_square_tower = 1'b1;
      DRAW_TOWER:  st.draw_tower         = 1'b1;
      default:     st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/tower_placer_control_btn_edge_sync.sv
// Button conditioner: 2-flop synchronizer, polarity normalisation, rising-edge detect on a 3rd flop.
module btn_edge_sync #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic rise_o
);

  logic       pressed;
  logic [2:0] sync_q;

  assign pressed = ACTIVE_LOW ? ~btn_i : btn_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], pressed};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tower_placer_control.sv
// Control FSM for the tower-placement datapath: cursor moves, tower placement and a draw watchdog.
module tower_placer_control
  import tower_placer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2047,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_place,
  input  logic square_done,
  input  logic erase_square_done,
  input  logic tower_done,
  input  logic valid,
  output logic top_left,
  output logic draw_square,
  output logic move_right,
  output logic move_down,
  output logic move_right_wait,
  output logic move_down_wait,
  output logic erase_square_right,
  output logic erase_square_down,
  output logic erase_square_tower,
  output logic draw_tower,
  output logic busy,
  output logic placed,
  output logic timeout_err
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic right_rise, down_rise, place_rise;

  btn_edge_sync #(.ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync_right (
    .clk(clk), .resetn(resetn), .btn_i(btn_right), .rise_o(right_rise));
  btn_edge_sync #(.ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync_down (
    .clk(clk), .resetn(resetn), .btn_i(btn_down), .rise_o(down_rise));
  btn_edge_sync #(.ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync_place (
    .clk(clk), .resetn(resetn), .btn_i(btn_place), .rise_o(place_rise));

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  strobes_t               strobes_q;
  logic                   busy_q, placed_q, timeout_err_q;
  logic                   waiting, abort;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    abort   = 1'b0;
    waiting = 1'b0;
    case (state_q)
      IDLE:        if (start) state_d = TOP_LEFT;
      TOP_LEFT:    state_d = DRAW_SQUARE;
      DRAW_SQUARE: begin waiting = 1'b1; if (square_done) state_d = WAIT_INPUT; end
      WAIT_INPUT: begin
        if (place_rise)      state_d = ERASE_TOWER;
        else if (right_rise) state_d = ERASE_RIGHT;
        else if (down_rise)  state_d = ERASE_DOWN;
      end
      ERASE_RIGHT: begin waiting = 1'b1; if (erase_square_done) state_d = MOVE_RIGHT; end
      MOVE_RIGHT:  begin waiting = 1'b1; if (valid) state_d = RIGHT_WAIT; end
      RIGHT_WAIT:  state_d = DRAW_SQUARE;
      ERASE_DOWN:  begin waiting = 1'b1; if (erase_square_done) state_d = MOVE_DOWN; end
      MOVE_DOWN:   begin waiting = 1'b1; if (valid) state_d = DOWN_WAIT; end
      DOWN_WAIT:   state_d = DRAW_SQUARE;
      ERASE_TOWER: begin waiting = 1'b1; if (erase_square_done) state_d = DRAW_TOWER; end
      DRAW_TOWER:  begin waiting = 1'b1; if (tower_done) state_d = DONE; end
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    // A completion in the final watchdog cycle still wins over the abort.
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (waiting) begin
      if (wd_q == WD_LAST) begin
        state_d = IDLE;
        wd_d    = '0;
        abort   = 1'b1;
      end else begin
        wd_d = wd_q + TIMEOUT_W'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      strobes_q     <= '0;
      busy_q        <= 1'b0;
      placed_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      strobes_q <= decode_strobes(state_d);
      busy_q    <= (state_d != IDLE);
      placed_q  <= (state_d == DONE);
      if (abort) begin
        timeout_err_q <= 1'b1;
      end else if (state_q == IDLE && start) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign top_left           = strobes_q.top_left;
  assign draw_square        = strobes_q.draw_square;
  assign move_right         = strobes_q.move_right;
  assign move_down          = strobes_q.move_down;
  assign move_right_wait    = strobes_q.move_right_wait;
  assign move_down_wait     = strobes_q.move_down_wait;
  assign erase_square_right = strobes_q.erase_square_right;
  assign erase_square_down  = strobes_q.erase_square_down;
  assign erase_square_tower = strobes_q.erase_square_tower;
  assign draw_tower         = strobes_q.draw_tower;
  assign busy               = busy_q;
  assign placed             = placed_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_tower_placer_control.sv
// Directed, table-driven bench for tower_placer_control with active-low buttons.
module tb_tower_placer_control;

  logic clk = 1'b0;
  logic resetn, start, btn_right, btn_down, btn_place;
  logic square_done, erase_square_done, tower_done, valid;
  logic top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
  logic erase_square_right, erase_square_down, erase_square_tower, draw_tower;
  logic busy, placed, timeout_err;

  always #5 clk = ~clk;

  tower_placer_control #(.TIMEOUT_CYCLES(2047), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .btn_right(btn_right), .btn_down(btn_down), .btn_place(btn_place),
    .square_done(square_done), .erase_square_done(erase_square_done),
    .tower_done(tower_done), .valid(valid),
    .top_left(top_left), .draw_square(draw_square),
    .move_right(move_right), .move_down(move_down),
    .move_right_wait(move_right_wait), .move_down_wait(move_down_wait),
    .erase_square_right(erase_square_right), .erase_square_down(erase_square_down),
    .erase_square_tower(erase_square_tower), .draw_tower(draw_tower),
    .busy(busy), .placed(placed), .timeout_err(timeout_err));

  logic [12:0] outs;
  assign outs = {top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait,
                 erase_square_right, erase_square_down, erase_square_tower, draw_tower,
                 busy, placed, timeout_err};

  localparam logic [12:0] B_TL = 13'h1000, B_DS = 13'h0800, B_MR = 13'h0400, B_MD = 13'h0200;
  localparam logic [12:0] B_MRW = 13'h0100, B_MDW = 13'h0080, B_ESR = 13'h0040, B_ESD = 13'h0020;
  localparam logic [12:0] B_EST = 13'h0010, B_DT = 13'h0008, B_BUSY = 13'h0004;
  localparam logic [12:0] B_PL = 13'h0002, B_TE = 13'h0001;

  localparam logic [12:0] S_IDLE = 13'h0000;
  localparam logic [12:0] S_TL   = B_TL  | B_BUSY;
  localparam logic [12:0] S_DS   = B_DS  | B_BUSY;
  localparam logic [12:0] S_WAIT = B_BUSY;
  localparam logic [12:0] S_ESR  = B_ESR | B_BUSY;
  localparam logic [12:0] S_MR   = B_MR  | B_BUSY;
  localparam logic [12:0] S_MRW  = B_MRW | B_BUSY;
  localparam logic [12:0] S_ESD  = B_ESD | B_BUSY;
  localparam logic [12:0] S_MD   = B_MD  | B_BUSY;
  localparam logic [12:0] S_MDW  = B_MDW | B_BUSY;
  localparam logic [12:0] S_EST  = B_EST | B_BUSY;
  localparam logic [12:0] S_DT   = B_DT  | B_BUSY;
  localparam logic [12:0] S_DONE = B_PL  | B_BUSY;

  // Input bits: start, right/down/place pressed, square_done, erase_done, tower_done, valid.
  localparam logic [7:0] I_S = 8'h80, I_R = 8'h40, I_D = 8'h20, I_P = 8'h10;
  localparam logic [7:0] I_SQ = 8'h08, I_ER = 8'h04, I_TW = 8'h02, I_VL = 8'h01, I_0 = 8'h00;

  typedef struct {
    logic [7:0]  ins;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [7:0] ins, input logic [12:0] exp, input string name);
    vec_t v;
    v.ins = ins; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic [7:0] v);
    start             = v[7];
    btn_right         = ~v[6];
    btn_down          = ~v[5];
    btn_place         = ~v[4];
    square_done       = v[3];
    erase_square_done = v[2];
    tower_done        = v[1];
    valid             = v[0];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [12:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %013b expected %013b", name, outs, exp);
    end
    checks++;
    if ($countones(outs[12:3]) > 1) begin
      errors++;
      $display("FAIL %s_onehot: strobes got %010b expected at most one high", name, outs[12:3]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Session: draw, move right, move down, then place with simultaneous place+down.
    add(I_S,        S_TL,   "start_top_left");
    add(I_0,        S_DS,   "draw_square_1");
    add(I_0,        S_DS,   "draw_square_hold");
    add(I_SQ,       S_WAIT, "square_done_wait");
    add(I_R,        S_WAIT, "right_sync1");
    add(I_R,        S_WAIT, "right_sync2");
    add(I_R,        S_ESR,  "right_edge_erase");
    add(I_R,        S_ESR,  "erase_right_hold");
    add(I_ER,       S_MR,   "move_right");
    add(I_0,        S_MR,   "move_right_hold");
    add(I_VL,       S_MRW,  "move_right_wait");
    add(I_0,        S_DS,   "redraw_after_right");
    add(I_SQ,       S_WAIT, "wait_after_right");
    add(I_D,        S_WAIT, "down_sync1");
    add(I_D,        S_WAIT, "down_sync2");
    add(I_0,        S_ESD,  "down_edge_erase");
    add(I_ER,       S_MD,   "move_down");
    add(I_VL,       S_MDW,  "move_down_wait");
    add(I_0,        S_DS,   "redraw_after_down");
    add(I_SQ,       S_WAIT, "wait_after_down");
    add(I_P | I_D,  S_WAIT, "place_down_sync1");
    add(I_P | I_D,  S_WAIT, "place_down_sync2");
    add(I_0,        S_EST,  "place_wins_erase");
    add(I_0,        S_EST,  "erase_tower_hold");
    add(I_ER,       S_DT,   "draw_tower");
    add(I_0,        S_DT,   "draw_tower_hold");
    add(I_TW,       S_DONE, "placed_pulse");
    add(I_0,        S_IDLE, "placed_cleared_idle");
    add(I_0,        S_IDLE, "idle_stays");

    resetn = 1'b0;
    apply(I_0);
    repeat (3) cyc();
    chk("reset_state", S_IDLE);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].ins);
      cyc();
      chk(tbl[i].name, tbl[i].exp);
    end

    // Right press during DRAW_SQUARE must be discarded, even while still held afterwards.
    apply(I_S); cyc(); chk("t4_top_left", S_TL);
    apply(I_0); cyc(); chk("t4_draw", S_DS);
    for (int i = 0; i < 5; i++) begin
      apply(I_R); cyc(); chk("t4_press_in_draw", S_DS);
    end
    apply(I_R | I_SQ); cyc(); chk("t4_enter_wait", S_WAIT);
    for (int i = 0; i < 5; i++) begin
      apply(I_R); cyc(); chk("t4_held_no_move", S_WAIT);
    end
    apply(I_0); cyc(); chk("t4_release_wait", S_WAIT);

    // Watchdog: square_done never arrives.
    resetn = 1'b0; cyc(); resetn = 1'b1;
    chk("t5_reset", S_IDLE);
    apply(I_S); cyc(); chk("t5_top_left", S_TL);
    apply(I_0);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (draw_square) cnt++;
      else break;
    end
    checks++;
    if (cnt != 2047) begin
      errors++;
      $display("FAIL t5_draw_cycles: got %0d expected 2047", cnt);
    end
    chk("t5_timeout_idle", B_TE);
    apply(I_0); cyc(); chk("t5_err_sticky", B_TE);
    apply(I_S); cyc(); chk("t5_restart_clears", S_TL);

    // Reset asserted while drawing the tower.
    apply(I_0);  cyc(); chk("t6_draw", S_DS);
    apply(I_SQ); cyc(); chk("t6_wait", S_WAIT);
    apply(I_P);  cyc(); cyc(); chk("t6_place_sync", S_WAIT);
    apply(I_0);  cyc(); chk("t6_erase_tower", S_EST);
    apply(I_ER); cyc(); chk("t6_draw_tower", S_DT);
    apply(I_0);
    resetn = 1'b0; cyc(); chk("t6_reset_mid", S_IDLE);
    resetn = 1'b1; cyc(); chk("t6_after_reset", S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
